uart_rx_buffer: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_buffer_if.sv | 27 ++
 rtl/byte_fifo_core.sv | 66 ++++++
 rtl/uart_rx_buffer.sv | 75 +++++++
 tb/tb_uart_rx_buffer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART peripheral constants: data width, default RX buffer depth and
// the register offsets decoded by the peripheral bus.
package uart_pkg;

  localparam int unsigned UART_DATA_W      = 8;
  localparam int unsigned UART_RXBUF_DEPTH = 8;

  // Byte offsets within the UART register window.
  localparam logic [7:0] UART_REG_DATA   = 8'h00;
  localparam logic [7:0] UART_REG_STATUS = 8'h04;
  localparam logic [7:0] UART_REG_CTRL   = 8'h08;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// CPU-side bus of the UART receive buffer. The CPU is the master; the buffer
// is the slave.
interface uart_rx_buffer_if #(
  parameter int unsigned AW = 3
);
  import uart_pkg::*;

  logic       rd_en;
  uart_byte_t rd_data;
  logic       rx_valid;
  logic [AW:0] rx_count;
  logic       full;
  logic       overrun;
  logic       ovr_clr;
  logic       irq;

  modport master (
    output rd_en, ovr_clr,
    input  rd_data, rx_valid, rx_count, full, overrun, irq
  );

  modport slave (
    input  rd_en, ovr_clr,
    output rd_data, rx_valid, rx_count, full, overrun, irq
  );

endinterface

// File: rtl/byte_fifo_core.sv
// First-word-fall-through byte FIFO: storage, wrapping pointers, occupancy
// counter and full/valid flags. A push while full is accepted only when a
// pop frees an entry in the same cycle; a pop while empty is ignored.
module byte_fifo_core
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        push,
  input  uart_byte_t  wdata,
  input  logic        pop,
  output uart_byte_t  rdata,
  output logic [AW:0] count,
  output logic [AW:0] count_next,
  output logic        full,
  output logic        valid,
  output logic        push_done,
  output logic        pop_done
);

  localparam logic [AW:0] CountFull = (AW+1)'(DEPTH);

  uart_byte_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;

  assign count = count_q;
  assign count_next = count_d;
  assign full = (count_q == CountFull);
  assign valid = (count_q != '0);
  assign rdata = valid ? mem[rd_ptr_q] : '0;

  // Qualify push/pop against occupancy and compute the next count.
  always_comb begin
    pop_done  = pop & valid;
    push_done = push & (~full | pop_done);
    count_d   = count_q;
    case ({push_done, pop_done})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and counter state; pointers wrap naturally at DEPTH.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_done) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_done)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge sysclk) begin
    if (push_done) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: turns each rising edge of the receiver's completion
// level into one FIFO push, and presents the bytes to the CPU with sticky
// overrun and a registered interrupt level.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = UART_RXBUF_DEPTH,
  parameter int unsigned AW        = 3,
  parameter int unsigned IRQ_LEVEL = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx_status,
  input  uart_byte_t rx_data,
  uart_rx_buffer_if.slave bus
);

  localparam logic [AW:0] IrqThresh = (AW+1)'(IRQ_LEVEL);

  logic        status_q;
  logic        push;
  logic        push_done, pop_done;
  logic [AW:0] count_next;
  logic        overrun_q, overrun_d;
  logic        irq_q, irq_d;

  // status_q resets high so a level already asserted at release never pushes.
  assign push = rx_status & ~status_q;

  byte_fifo_core #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .sysclk     (sysclk),
    .reset      (reset),
    .push       (push),
    .wdata      (rx_data),
    .pop        (bus.rd_en),
    .rdata      (bus.rd_data),
    .count      (bus.rx_count),
    .count_next (count_next),
    .full       (bus.full),
    .valid      (bus.rx_valid),
    .push_done  (push_done),
    .pop_done   (pop_done)
  );

  // Sticky overrun (set beats clear) and interrupt level from next-state values.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.ovr_clr) overrun_d = 1'b0;
    if (push & ~push_done) overrun_d = 1'b1;
    irq_d = (count_next >= IrqThresh) | overrun_d;
  end

  // Edge-detect, overrun and irq registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      status_q  <= 1'b1;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      status_q  <= rx_status;
      overrun_q <= overrun_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.overrun = overrun_q;
  assign bus.irq     = irq_q;

  logic unused_pop;
  assign unused_pop = pop_done;

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       rx_status = 1'b0;
  uart_byte_t rx_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  uart_byte_t exp_q[$];
  logic       exp_ovr = 1'b0;

  uart_rx_buffer_if #(.AW(AW)) bus ();

  uart_rx_buffer #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .IRQ_LEVEL (1)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .rx_status (rx_status),
    .rx_data   (rx_data),
    .bus       (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard model of one push attempt.
  task automatic model_push(input uart_byte_t d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovr = 1'b1;
  endtask

  // One strobe held for 'hold' cycles, then released for one cycle.
  task automatic push_byte(input uart_byte_t d, input int hold);
    rx_status = 1'b1;
    rx_data   = d;
    model_push(d);
    repeat (hold) tick();
    rx_status = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string tag);
    uart_byte_t e;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.rd_data), 32'(e));
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk({tag, "_count"}, 32'(bus.rx_count), 32'(exp_q.size()));
  endtask

  initial begin
    bus.rd_en   = 1'b0;
    bus.ovr_clr = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_count", 32'(bus.rx_count), 32'd0);
    chk("rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_data", 32'(bus.rd_data), 32'd0);

    // Single byte, level held 5 cycles
    rx_status = 1'b1;
    rx_data   = 8'hA5;
    model_push(8'hA5);
    tick();
    chk("single_valid", 32'(bus.rx_valid), 32'd1);
    chk("single_data", 32'(bus.rd_data), 32'hA5);
    chk("single_count", 32'(bus.rx_count), 32'd1);
    chk("single_irq", 32'(bus.irq), 32'd1);
    repeat (4) tick();
    chk("single_onepush", 32'(bus.rx_count), 32'd1);
    rx_status = 1'b0;
    tick();
    pop_check("single_pop");
    chk("single_empty", 32'(bus.rx_valid), 32'd0);
    chk("single_irq0", 32'(bus.irq), 32'd0);

    // Fill and overrun
    for (int i = 1; i <= 8; i++) push_byte(uart_byte_t'(i), 1);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.rx_count), 32'd8);
    chk("fill_ovr0", 32'(bus.overrun), 32'd0);
    push_byte(8'h09, 1);
    chk("ovr_set", 32'(bus.overrun), 32'(exp_ovr));
    chk("ovr_count", 32'(bus.rx_count), 32'd8);
    for (int i = 0; i < 8; i++) pop_check("fill_pop");
    chk("fill_drained", 32'(bus.rx_valid), 32'd0);
    chk("fill_irq_ovr", 32'(bus.irq), 32'd1);
    bus.ovr_clr = 1'b1;
    exp_ovr = 1'b0;
    tick();
    bus.ovr_clr = 1'b0;
    chk("clr_ovr", 32'(bus.overrun), 32'(exp_ovr));
    chk("clr_irq", 32'(bus.irq), 32'd0);

    // Push and pop together at full
    for (int i = 0; i < 8; i++) push_byte(uart_byte_t'(8'h10 + i), 1);
    rx_status = 1'b1;
    rx_data   = 8'h20;
    chk("sim_head", 32'(bus.rd_data), 32'h10);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    void'(exp_q.pop_front());
    model_push(8'h20);
    chk("sim_count", 32'(bus.rx_count), 32'd8);
    chk("sim_ovr", 32'(bus.overrun), 32'd0);
    rx_status = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) pop_check("sim_pop");

    // Wrap-around with interleaved push/pop pairs
    for (int i = 0; i < 20; i++) begin
      push_byte(uart_byte_t'(8'h40 + i), 1);
      chk("wrap_count", 32'(bus.rx_count), 32'd1);
      pop_check("wrap_pop");
      chk("wrap_full", 32'(bus.full), 32'd0);
      chk("wrap_ovr", 32'(bus.overrun), 32'd0);
    end

    // Pop while empty is ignored
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("epop_count", 32'(bus.rx_count), 32'd0);
    chk("epop_valid", 32'(bus.rx_valid), 32'd0);
    chk("epop_ovr", 32'(bus.overrun), 32'd0);
    chk("epop_data", 32'(bus.rd_data), 32'd0);

    // Clear and set of overrun in the same cycle: set wins
    for (int i = 0; i < 8; i++) push_byte(uart_byte_t'(8'h30 + i), 1);
    rx_status   = 1'b1;
    rx_data     = 8'h38;
    bus.ovr_clr = 1'b1;
    model_push(8'h38);
    tick();
    bus.ovr_clr = 1'b0;
    rx_status   = 1'b0;
    chk("race_ovr", 32'(bus.overrun), 32'(exp_ovr));
    chk("race_count", 32'(bus.rx_count), 32'd8);
    tick();
    bus.ovr_clr = 1'b1;
    exp_ovr = 1'b0;
    tick();
    bus.ovr_clr = 1'b0;
    chk("race_clr", 32'(bus.overrun), 32'd0);
    chk("race_irq", 32'(bus.irq), 32'd1);

    // Reset mid-operation with strobe still high
    for (int i = 0; i < 6; i++) pop_check("pre_rst_pop");
    rx_status = 1'b1;
    rx_data   = 8'h55;
    model_push(8'h55);
    tick();
    chk("pre_rst_count", 32'(bus.rx_count), 32'd3);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_count", 32'(bus.rx_count), 32'd0);
    chk("async_rst_irq", 32'(bus.irq), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_count", 32'(bus.rx_count), 32'd0);
    chk("post_rst_valid", 32'(bus.rx_valid), 32'd0);
    chk("post_rst_data", 32'(bus.rd_data), 32'd0);
    chk("post_rst_full", 32'(bus.full), 32'd0);
    chk("post_rst_ovr", 32'(bus.overrun), 32'd0);
    chk("post_rst_irq", 32'(bus.irq), 32'd0);
    rx_status = 1'b0;
    tick();
    push_byte(8'h66, 2);
    chk("after_rst_count", 32'(bus.rx_count), 32'd1);
    pop_check("after_rst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
